// File: rtl/vault_pkg.sv
// Shared types and helpers for the vault quorum controller: state encoding,
// blink divider derivation, counter sizing and the key popcount.
package vault_pkg;

  typedef enum logic [2:0] {
    LOCKED   = 3'd0,
    ARMING   = 3'd1,
    UNLOCKED = 3'd2,
    HOLDOFF  = 3'd3,
    LOCKOUT  = 3'd4
  } state_t;

  function automatic int blink_div(input int clk_hz, input int blink_hz);
    return clk_hz / (2 * blink_hz);
  endfunction

  // Counter holding 0..terminal-1; never narrower than one bit.
  function automatic int cnt_w(input int terminal);
    return (terminal > 1) ? $clog2(terminal) : 1;
  endfunction

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/vault_tick_gen.sv
// Free-running divider producing a one-cycle tick every BLINK_DIV clocks.
module vault_tick_gen
  import vault_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int BLINK_HZ = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int BLINK_DIV = blink_div(CLK_HZ, BLINK_HZ);
  localparam int CW = cnt_w(BLINK_DIV);
  localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/vault_quorum_controller.sv
// Vault unlock FSM with president / VP-quorum authorisation, arming delay,
// auto and forced relock. Define VAULT_LOCKOUT_EN for abort-count tamper lockout.
module vault_quorum_controller
  import vault_pkg::*;
#(
  parameter int N_VP          = 2,
  parameter int VP_QUORUM     = 2,
  parameter int CLK_HZ        = 100_000_000,
  parameter int BLINK_HZ      = 1,
  parameter int LED_W         = 8,
  parameter int ARM_TICKS     = 2,
  parameter int RELOCK_TICKS  = 20,
  parameter int MAX_ABORTS    = 3,
  parameter int LOCKOUT_TICKS = 60
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             p,
  input  logic [N_VP-1:0]  vp,
  input  logic             open,
  input  logic             relock,
  output logic [LED_W-1:0] led,
  output logic             unlock,
  output logic             lockout
);

  localparam int ARM_W = cnt_w(ARM_TICKS);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'((ARM_TICKS > 0) ? ARM_TICKS - 1 : 0);
  localparam int RL_W = cnt_w(RELOCK_TICKS);
  localparam logic [RL_W-1:0] RL_LAST = RL_W'((RELOCK_TICKS > 0) ? RELOCK_TICKS - 1 : 0);

  logic            p_s1, p_s2, open_s1, open_s2;
  logic [N_VP-1:0] vp_s1, vp_s2;
  logic [31:0]     vp_n;
  logic            auth, tick;

  state_t           state, state_nxt;
  logic [ARM_W-1:0] arm_cnt, arm_nxt;
  logic [RL_W-1:0]  relock_cnt, rl_nxt;
  logic [LED_W-1:0] led_nxt;

  // Two-flop synchronisers on the asynchronous switches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_s1 <= 1'b0; p_s2 <= 1'b0;
      open_s1 <= 1'b0; open_s2 <= 1'b0;
      vp_s1 <= '0; vp_s2 <= '0;
    end else begin
      p_s1 <= p; p_s2 <= p_s1;
      open_s1 <= open; open_s2 <= open_s1;
      vp_s1 <= vp; vp_s2 <= vp_s1;
    end
  end

  assign vp_n = popcount(32'(vp_s2));
  assign auth = (p_s2 && vp_n >= 32'd1) || (open_s2 && p_s2) ||
                (open_s2 && vp_n >= 32'(VP_QUORUM));

  vault_tick_gen #(.CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

`ifdef VAULT_LOCKOUT_EN
  localparam int AB_W = cnt_w(MAX_ABORTS);
  localparam logic [AB_W-1:0] AB_LAST = AB_W'(MAX_ABORTS - 1);
  localparam int LO_W = cnt_w(LOCKOUT_TICKS);
  localparam logic [LO_W-1:0] LO_LAST = LO_W'(LOCKOUT_TICKS - 1);

  function automatic logic [LED_W-1:0] alt_pattern();
    logic [LED_W-1:0] v;
    for (int i = 0; i < LED_W; i++) v[i] = i[0];
    return v;
  endfunction

  localparam logic [LED_W-1:0] ALT = alt_pattern();

  logic [AB_W-1:0] abort_cnt, abort_nxt;
  logic [LO_W-1:0] lo_cnt, lo_nxt;
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(MAX_ABORTS), 32'(LOCKOUT_TICKS)};
  assign lockout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    arm_nxt   = arm_cnt;
    rl_nxt    = relock_cnt;
    led_nxt   = led;
`ifdef VAULT_LOCKOUT_EN
    abort_nxt = abort_cnt;
    lo_nxt    = lo_cnt;
`endif
    case (state)
      LOCKED: begin
        led_nxt = '0;
        if (auth) begin
          if (ARM_TICKS == 0) state_nxt = UNLOCKED;
          else begin
            state_nxt = ARMING;
            arm_nxt   = '0;
          end
        end
      end
      ARMING: begin
        led_nxt = '0;
        if (!auth) begin
`ifdef VAULT_LOCKOUT_EN
          if (abort_cnt == AB_LAST) begin
            state_nxt = LOCKOUT;
            abort_nxt = '0;
            lo_nxt    = '0;
            led_nxt   = ALT;
          end else begin
            state_nxt = LOCKED;
            abort_nxt = abort_cnt + 1'b1;
          end
`else
          state_nxt = LOCKED;
`endif
        end else if (relock) begin
          state_nxt = HOLDOFF;
        end else if (tick) begin
          if (arm_cnt == ARM_LAST) state_nxt = UNLOCKED;
          else                     arm_nxt = arm_cnt + 1'b1;
        end
      end
      UNLOCKED: begin
        if (!auth) begin
          state_nxt = LOCKED;
          led_nxt   = '0;
        end else if (relock || (tick && RELOCK_TICKS != 0 && relock_cnt == RL_LAST)) begin
          state_nxt = HOLDOFF;
          led_nxt   = '0;
        end else if (tick) begin
          led_nxt = ~led;
          // With auto-relock disabled the counter is parked to avoid wrapping
          if (RELOCK_TICKS != 0) rl_nxt = relock_cnt + 1'b1;
        end
      end
      HOLDOFF: begin
        led_nxt = '0;
        if (!auth) state_nxt = LOCKED;
      end
`ifdef VAULT_LOCKOUT_EN
      LOCKOUT: begin
        if (tick) begin
          if (lo_cnt == LO_LAST) begin
            state_nxt = HOLDOFF;
            led_nxt   = '0;
          end else begin
            led_nxt = ~led;
            lo_nxt  = lo_cnt + 1'b1;
          end
        end
      end
`endif
      default: begin
        state_nxt = LOCKED;
        led_nxt   = '0;
      end
    endcase

    if (state_nxt == UNLOCKED && state != UNLOCKED) begin
      led_nxt = '1;
      rl_nxt  = '0;
`ifdef VAULT_LOCKOUT_EN
      abort_nxt = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOCKED;
      arm_cnt    <= '0;
      relock_cnt <= '0;
      led        <= '0;
      unlock     <= 1'b0;
`ifdef VAULT_LOCKOUT_EN
      abort_cnt  <= '0;
      lo_cnt     <= '0;
      lockout    <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      arm_cnt    <= arm_nxt;
      relock_cnt <= rl_nxt;
      led        <= led_nxt;
      unlock     <= (state_nxt == UNLOCKED);
`ifdef VAULT_LOCKOUT_EN
      abort_cnt  <= abort_nxt;
      lo_cnt     <= lo_nxt;
      lockout    <= (state_nxt == LOCKOUT);
`endif
    end
  end

endmodule

// File: tb/tb_vault_quorum_controller.sv
// Scoreboard bench for vault_quorum_controller: stimulus queues expected output
// changes (with their clock cycle); a negedge monitor pops and compares them.
module tb_vault_quorum_controller;

  logic       clk = 1'b0, rst_n = 1'b1, p = 1'b0, open = 1'b0, relock = 1'b0;
  logic [1:0] vp = 2'b00;
  logic [7:0] led;
  logic       unlock, lockout;

  vault_quorum_controller #(
    .N_VP(2), .VP_QUORUM(2), .CLK_HZ(20), .BLINK_HZ(1), .LED_W(8),
    .ARM_TICKS(2), .RELOCK_TICKS(4), .MAX_ABORTS(3), .LOCKOUT_TICKS(5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .p       (p),
    .vp      (vp),
    .open    (open),
    .relock  (relock),
    .led     (led),
    .unlock  (unlock),
    .lockout (lockout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         cyc;
    bit         drain;
    logic       lockout;
    logic       unlock;
    logic [7:0] led;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       probe_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [9:0] prev = '0;

  // Cycle k = k-th rising edge after reset release; ticks land on multiples of 10
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic at_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic keys(input logic pp, input logic [1:0] v, input logic o);
    p = pp; vp = v; open = o;
  endtask

  task automatic expect_ev(input string nm, input int c, input logic lo,
                           input logic un, input logic [7:0] l);
    exp_t e;
    e.name = nm; e.cyc = c; e.drain = 1'b0;
    e.lockout = lo; e.unlock = un; e.led = l;
    exp_q.push_back(e);
  endtask

  task automatic probe(input string nm, input bit dr, input logic lo,
                       input logic un, input logic [7:0] l);
    exp_t e;
    e.name = nm; e.cyc = -1; e.drain = dr;
    e.lockout = lo; e.unlock = un; e.led = l;
    probe_q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (probe_q.size() != 0) begin
        e = probe_q.pop_front();
        checks++;
        if (e.drain) begin
          if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s: %0d expected output changes never seen, required 0",
                     e.name, exp_q.size());
          end
        end else if ({lockout, unlock, led} !== {e.lockout, e.unlock, e.led}) begin
          failures++;
          $display("FAIL %s: got lockout=%b unlock=%b led=%h, required lockout=%b unlock=%b led=%h",
                   e.name, lockout, unlock, led, e.lockout, e.unlock, e.led);
        end
      end
      if (!rst_n) begin
        prev = '0;
      end else if ({lockout, unlock, led} !== prev) begin
        prev = {lockout, unlock, led};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change: got cyc=%0d lockout=%b unlock=%b led=%h, required no change",
                   cyc, lockout, unlock, led);
        end else begin
          e = exp_q.pop_front();
          if (cyc != e.cyc || {lockout, unlock, led} !== {e.lockout, e.unlock, e.led}) begin
            failures++;
            $display("FAIL %s: got cyc=%0d lockout=%b unlock=%b led=%h, required cyc=%0d lockout=%b unlock=%b led=%h",
                     e.name, cyc, lockout, unlock, led, e.cyc, e.lockout, e.unlock, e.led);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    #1 rst_n = 1'b0;
    probe("reset_state", 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // President + one VP: arm 2 ticks, blink, auto-relock after 4 ticks
    at_cyc(2);   keys(1'b1, 2'b01, 1'b0);
    expect_ev("arm_unlock",  20, 1'b0, 1'b1, 8'hFF);
    expect_ev("blink_off",   30, 1'b0, 1'b1, 8'h00);
    expect_ev("blink_on",    40, 1'b0, 1'b1, 8'hFF);
    expect_ev("blink_off2",  50, 1'b0, 1'b1, 8'h00);
    expect_ev("auto_relock", 60, 1'b0, 1'b0, 8'h00);
    at_cyc(90);  keys(1'b0, 2'b00, 1'b0);
    at_cyc(100); keys(1'b1, 2'b01, 1'b0);
    expect_ev("reunlock", 120, 1'b0, 1'b1, 8'hFF);

    // Forced relock pulse
    at_cyc(125); relock = 1'b1;
    expect_ev("forced_relock", 126, 1'b0, 1'b0, 8'h00);
    at_cyc(126); relock = 1'b0;
    at_cyc(130); keys(1'b0, 2'b00, 1'b0);

    // Abort after one tick, then a full re-arm is needed
    at_cyc(140); keys(1'b1, 2'b10, 1'b0);
    at_cyc(152); keys(1'b0, 2'b00, 1'b0);
    at_cyc(162); keys(1'b1, 2'b10, 1'b0);
    expect_ev("rearm_full", 180, 1'b0, 1'b1, 8'hFF);

    // Open bank: one VP short of quorum, then quorum, then drop
    at_cyc(182); keys(1'b0, 2'b01, 1'b1);
    expect_ev("quorum_short", 185, 1'b0, 1'b0, 8'h00);
    at_cyc(240); keys(1'b0, 2'b11, 1'b1);
    expect_ev("quorum_unlock", 260, 1'b0, 1'b1, 8'hFF);
    at_cyc(262); keys(1'b0, 2'b00, 1'b1);
    expect_ev("quorum_drop", 265, 1'b0, 1'b0, 8'h00);

    // Asynchronous reset while unlocked, keys held through release
    at_cyc(270); keys(1'b1, 2'b01, 1'b0);
    expect_ev("pre_reset_unlock", 290, 1'b0, 1'b1, 8'hFF);
    at_cyc(292);
    #2 rst_n = 1'b0;
    probe("async_reset", 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    expect_ev("post_reset_unlock", 20, 1'b0, 1'b1, 8'hFF);
    at_cyc(22); keys(1'b0, 2'b00, 1'b0);
    expect_ev("post_reset_drop", 25, 1'b0, 1'b0, 8'h00);

    // Three consecutive arming aborts
    for (int i = 0; i < 3; i++) begin
      at_cyc(32 + 10 * i); keys(1'b1, 2'b01, 1'b0);
      at_cyc(37 + 10 * i); keys(1'b0, 2'b00, 1'b0);
    end
`ifdef VAULT_LOCKOUT_EN
    expect_ev("lockout_entry", 60, 1'b1, 1'b0, 8'hAA);
    at_cyc(62); keys(1'b1, 2'b01, 1'b0);
    expect_ev("lockout_t1",   70,  1'b1, 1'b0, 8'h55);
    expect_ev("lockout_t2",   80,  1'b1, 1'b0, 8'hAA);
    expect_ev("lockout_t3",   90,  1'b1, 1'b0, 8'h55);
    expect_ev("lockout_t4",   100, 1'b1, 1'b0, 8'hAA);
    expect_ev("lockout_exit", 110, 1'b0, 1'b0, 8'h00);
    at_cyc(140); keys(1'b0, 2'b00, 1'b0);
`else
    at_cyc(62);
    probe("no_lockout", 1'b0, 1'b0, 1'b0, 8'h00);
`endif

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #2 probe("drain", 1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
